// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Op encodings, FSM states and sizing helpers for muldiv_ctrl.
// Revision    : 1.0
// ============================================================================
package muldiv_pkg;

  localparam int unsigned MD_WIDTH = 32;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

  localparam int unsigned MD_CNT_W = cnt_width(MD_WIDTH);

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_step
// Description : One combinational iteration of shift-add multiply or
//               restoring subtract-shift divide on unsigned magnitudes.
// Revision    : 1.0
// ============================================================================
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic                 i_div,
  input  logic [2*WIDTH-1:0]   i_acc,
  input  logic [2*WIDTH-1:0]   i_opa,
  input  logic [WIDTH-1:0]     i_opb,
  output logic [2*WIDTH-1:0]   o_acc,
  output logic [2*WIDTH-1:0]   o_opa,
  output logic [WIDTH-1:0]     o_opb
);

  // Divide: acc holds the partial remainder, opa the divisor, opb the
  // dividend bits still to shift in (quotient bits enter at the bottom).
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH+1:0] w_diff;
  logic             w_fits;

  assign w_rem_sh = {i_acc[WIDTH-1:0], i_opb[WIDTH-1]};
  assign w_diff   = {1'b0, w_rem_sh} - {2'b00, i_opa[WIDTH-1:0]};
  assign w_fits   = ~w_diff[WIDTH+1];

  always_comb begin
    o_acc = i_acc;
    o_opa = i_opa;
    o_opb = i_opb;
    if (i_div) begin
      o_acc = {{(WIDTH-1){1'b0}}, (w_fits ? w_diff[WIDTH:0] : w_rem_sh)};
      o_opb = {i_opb[WIDTH-2:0], w_fits};
    end else begin
      o_acc = i_acc + (i_opb[0] ? i_opa : {(2*WIDTH){1'b0}});
      o_opa = {i_opa[2*WIDTH-2:0], 1'b0};
      o_opb = {1'b0, i_opb[WIDTH-1:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_ctrl
// Description : Iterative MULT/MULTU/DIV/DIVU sequencer with HI/LO and stall.
//               Optional MULDIV_EARLY_OUT_EN: multiply ends once the
//               remaining multiplier is zero.
// Revision    : 1.0
// ============================================================================
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             StartE,
  input  logic [1:0]       OpE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             FlushE,
  input  logic             MfHiE,
  input  logic             MfLoE,
  output logic [WIDTH-1:0] HiLoE,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             StallMD
);

  localparam int               c_cnt_w    = cnt_width(WIDTH);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_is_div;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_opa;
  logic [WIDTH-1:0]   r_opb;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [2*WIDTH-1:0] w_opa_nxt;
  logic [WIDTH-1:0]   w_opb_nxt;
  logic               w_busy;
  logic               w_stall;
  logic               w_accept;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic               w_mul_done;
  logic               w_zero_start;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_hi_res;
  logic [WIDTH-1:0]   w_lo_res;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_div (r_is_div),
    .i_acc (r_acc),
    .i_opa (r_opa),
    .i_opb (r_opb),
    .o_acc (w_acc_nxt),
    .o_opa (w_opa_nxt),
    .o_opb (w_opb_nxt)
  );

  assign w_busy   = (r_state != ST_IDLE);
  assign w_stall  = w_busy & ~FlushE & (StartE | MfHiE | MfLoE);
  assign w_accept = (r_state == ST_IDLE) & StartE & ~FlushE & ~w_stall;

  assign w_sa    = op_is_signed(OpE) & SrcAE[WIDTH-1];
  assign w_sb    = op_is_signed(OpE) & SrcBE[WIDTH-1];
  assign w_abs_a = w_sa ? -SrcAE : SrcAE;
  assign w_abs_b = w_sb ? -SrcBE : SrcBE;

`ifdef MULDIV_EARLY_OUT_EN
  assign w_mul_done   = ~r_is_div & (w_opb_nxt == {WIDTH{1'b0}});
  assign w_zero_start = ~op_is_div(OpE) & (SrcBE == {WIDTH{1'b0}});
`else
  assign w_mul_done   = 1'b0;
  assign w_zero_start = 1'b0;
`endif

  // Magnitudes are computed unsigned; signs are restored only in FIX.
  assign w_prod   = r_neg_res ? -r_acc : r_acc;
  assign w_quo    = r_neg_res ? -r_opb : r_opb;
  assign w_rem    = r_neg_rem ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_hi_res = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
  assign w_lo_res = r_is_div ? w_quo : w_prod[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_zero_start ? ST_FIX : ST_RUN;
        end
      end
      ST_RUN: begin
        if ((r_cnt == c_cnt_last) || w_mul_done) begin
          w_state_nxt = ST_FIX;
        end
      end
      ST_FIX:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_acc     <= '0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_cnt     <= '0;
            r_is_div  <= op_is_div(OpE);
            r_neg_res <= w_sa ^ w_sb;
            r_neg_rem <= w_sa;
            r_acc     <= '0;
            if (op_is_div(OpE)) begin
              r_opa <= {{WIDTH{1'b0}}, w_abs_b};
              r_opb <= w_abs_a;
            end else begin
              r_opa <= {{WIDTH{1'b0}}, w_abs_a};
              r_opb <= w_abs_b;
            end
          end
        end
        ST_RUN: begin
          r_cnt <= r_cnt + c_cnt_w'(1);
          r_acc <= w_acc_nxt;
          r_opa <= w_opa_nxt;
          r_opb <= w_opb_nxt;
        end
        ST_FIX: begin
          r_hi <= w_hi_res;
          r_lo <= w_lo_res;
        end
        default: ;
      endcase
    end
  end

  assign Hi      = r_hi;
  assign Lo      = r_lo;
  assign Busy    = w_busy;
  assign StallMD = w_stall;
  assign HiLoE   = MfHiE ? r_hi : (MfLoE ? r_lo : {WIDTH{1'b0}});

endmodule
`default_nettype wire
